// File: rtl/lasd_pkg.sv
// Shared FSM states, serial frame size and baud divisor helper for the register-file UART dump.
package lasd_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, FIN} state_t;

   localparam int FRAME_BITS = 10;

   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serialiser: txd drops the edge after tx_start, each bit lasts CLKS_PER_BIT cycles.
// tx_start is ignored while a frame is in flight; tx_done flags the last cycle of the stop bit.
module uart_tx
   import lasd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       txd,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int                CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  LP_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        LP_BIT_STOP  = 4'(FRAME_BITS - 1);
   localparam logic [3:0]        LP_BIT_MSB   = 4'(FRAME_BITS - 2);

   logic             r_active;
   logic [CNT_W-1:0] r_baud;
   logic [3:0]       r_bit;
   logic [7:0]       r_shift;
   logic             r_txd;
   logic             w_bit_end;

   assign w_bit_end = r_active && (r_baud == LP_BAUD_LAST);
   assign tx_done   = w_bit_end && (r_bit == LP_BIT_STOP);
   assign tx_busy   = r_active;
   assign txd       = r_txd;

   // r_bit: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_txd    <= 1'b1;
      end else if (!r_active) begin
         if (tx_start) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= tx_data;
            r_txd    <= 1'b0;
         end
      end else if (w_bit_end) begin
         r_baud <= '0;
         if (r_bit == LP_BIT_STOP) begin
            r_active <= 1'b0;
            r_txd    <= 1'b1;
         end else begin
            r_bit <= r_bit + 4'd1;
            if (r_bit == LP_BIT_MSB) begin
               r_txd <= 1'b1;
            end else begin
               r_txd   <= r_shift[0];
               r_shift <= {1'b0, r_shift[7:1]};
            end
         end
      end else begin
         r_baud <= r_baud + CNT_W'(1);
      end
   end

endmodule

// File: rtl/regfile_uart_dump.sv
// Walks register addresses 0..NREGS-1 and sends each byte as 8N1; first start bit 3 cycles after start,
// 2 idle cycles between frames. start is ignored while busy; if held it re-arms straight out of FIN.
module regfile_uart_dump
   import lasd_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
   parameter int NREGS        = 8,
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] rd,
   output logic              txd,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LP_RA_LAST = ADDR_W'(NREGS - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_ra;
   logic [ADDR_W-1:0] w_ra_nxt;
   logic              w_tx_start;
   logic              w_tx_busy;
   logic              w_tx_done;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_start (w_tx_start),
      .tx_data  (rd),
      .txd      (txd),
      .tx_busy  (w_tx_busy),
      .tx_done  (w_tx_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ra    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ra    <= w_ra_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ra_nxt    = r_ra;
      w_tx_start  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = FETCH;
               w_ra_nxt    = '0;
            end
         end
         FETCH: w_state_nxt = LOAD;
         LOAD: begin
            // rd is frozen into the transmitter here; later writes only reach later addresses
            if (!w_tx_busy) begin
               w_tx_start  = 1'b1;
               w_state_nxt = SEND;
            end
         end
         SEND: begin
            if (w_tx_done) begin
               if (r_ra == LP_RA_LAST) begin
                  w_state_nxt = FIN;
               end else begin
                  w_ra_nxt    = r_ra + ADDR_W'(1);
                  w_state_nxt = FETCH;
               end
            end
         end
         FIN: begin
            if (start) begin
               w_state_nxt = FETCH;
               w_ra_nxt    = '0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign ra   = r_ra;
   assign busy = (r_state == FETCH) || (r_state == LOAD) || (r_state == SEND);
   assign done = (r_state == FIN);

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Bench for regfile_uart_dump at 4 clocks per bit: stimulus queues expected frames and done cycles,
// a negedge monitor decodes txd and pops the queues.
module tb_regfile_uart_dump;

   localparam int CPB       = 4;
   localparam int FRAME_CYC = 10 * CPB;               // 40
   localparam int FRAME_GAP = FRAME_CYC + 2;          // 42: frame plus FETCH/LOAD
   localparam int DUMP_CYC  = 8 * FRAME_CYC + 7 * 2;  // 334: first start bit to done

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] ra;
   logic [7:0] rd;
   logic       txd;
   logic       busy;
   logic       done;
   logic [7:0] regs [8];

   frame_t      fq[$];
   int          dq[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          frame_cnt = 0;
   logic [39:0] last_smp = '0;
   logic [39:0] smp = '0;
   int          nsmp = 0;
   int          fall_cyc = 0;
   logic        in_frame = 1'b0;
   logic        prev_txd = 1'b1;

   regfile_uart_dump #(
      .CLK_FREQ     (40),
      .BAUD         (10),
      .CLKS_PER_BIT (CPB),
      .NREGS        (8),
      .ADDR_W       (3),
      .DATA_W       (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ra    (ra),
      .rd    (rd),
      .txd   (txd),
      .busy  (busy),
      .done  (done)
   );

   assign rd = regs[ra];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [39:0] expand(input logic [7:0] b);
      logic [39:0] v;
      logic        lvl;
      v = '0;
      for (int i = 0; i < 10; i++) begin
         if (i == 0)      lvl = 1'b0;
         else if (i == 9) lvl = 1'b1;
         else             lvl = b[i-1];
         for (int r = 0; r < CPB; r++) v = {v[38:0], lvl};
      end
      return v;
   endfunction

   task automatic frame_check();
      frame_t e;
      if (fq.size() != 0) begin
         e = fq.pop_front();
      end else begin
         e.data = 8'h00;
         e.cyc  = -1;
      end
      chk("frame_bits", smp, expand(e.data));
      chk("frame_start_cycle", fall_cyc, e.cyc);
      last_smp = smp;
      frame_cnt++;
   endtask

   // monitor
   initial begin
      int exp_done;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame = 1'b0;
            prev_txd = 1'b1;
         end else begin
            if (done) begin
               chk("busy_low_in_done", busy, 0);
               if (dq.size() != 0) exp_done = dq.pop_front();
               else                exp_done = -1;
               chk("done_cycle", cyc, exp_done);
            end
            if (in_frame) begin
               smp = {smp[38:0], txd};
               nsmp++;
               if (nsmp == FRAME_CYC) begin
                  in_frame = 1'b0;
                  frame_check();
               end
            end else if (prev_txd && !txd) begin
               in_frame = 1'b1;
               smp      = {39'd0, txd};
               nsmp     = 1;
               fall_cyc = cyc;
            end
            prev_txd = txd;
         end
      end
   end

   task automatic preload(output logic [7:0][7:0] b);
      for (int j = 0; j < 8; j++) begin
         regs[j] = 8'(j * 17);
         b[j]    = 8'(j * 17);
      end
   endtask

   // k is the cycle in which start is high; its start bit is observed at k+3
   task automatic push_dump(input int k, input logic [7:0][7:0] b);
      frame_t e;
      for (int j = 0; j < 8; j++) begin
         e.data = b[j];
         e.cyc  = k + 3 + j * FRAME_GAP;
         fq.push_back(e);
      end
      dq.push_back(k + 3 + DUMP_CYC);
   endtask

   task automatic start_dump(output int k);
      @(posedge clk); #1;
      start = 1'b1;
      k     = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((fq.size() != 0 || dq.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk({name, "_frames_left"}, fq.size(), 0);
      chk({name, "_done_left"}, dq.size(), 0);
   endtask

   initial begin
      #(10 * 20000);
      $display("FAIL watchdog: simulation exceeded 20000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0][7:0] b;
      int k;
      int fc0;
      int n;

      preload(b);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 1: quiet after reset
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_outputs", {txd, busy, done, ra}, 6'b100000);
      end

      // 2: single dump of 0x00..0x77
      preload(b);
      start_dump(k);
      push_dump(k, b);
      chk("busy_after_start", busy, 1);
      drain("single");

      // 3: bit order on 0xA5
      preload(b);
      regs[0] = 8'hA5;
      b[0]    = 8'hA5;
      fc0     = frame_cnt;
      start_dump(k);
      push_dump(k, b);
      n = 0;
      while (frame_cnt == fc0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bitorder_a5", last_smp, 40'h0F0F00F0FF);
      drain("bitorder");

      // 4: writes and start during frame 0
      preload(b);
      b[5] = 8'h3C;
      start_dump(k);
      push_dump(k, b);
      wait_cyc(k + 13);
      regs[0] = 8'hFF;
      regs[5] = 8'h3C;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      drain("snapshot");
      repeat (100) @(posedge clk);
      #1 chk("no_second_dump", busy, 0);

      // 5: reset inside bit 4 of frame 2 (byte 0x22, that bit is 0)
      preload(b);
      start_dump(k);
      push_dump(k, b);
      wait_cyc(k + 3 + 2 * FRAME_GAP + 4 * CPB + 1);
      chk("pre_reset_txd", txd, 0);
      #1 rst = 1'b1;
      #1;
      chk("reset_txd_high", txd, 1);
      chk("reset_busy", busy, 0);
      chk("reset_ra", ra, 0);
      chk("reset_done", done, 0);
      fq.delete();
      dq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      start_dump(k);
      push_dump(k, b);
      drain("after_reset");

      // 6: start held for two back-to-back dumps
      preload(b);
      @(posedge clk); #1;
      start = 1'b1;
      k     = cyc;
      push_dump(k, b);
      push_dump(k + 3 + DUMP_CYC, b);
      wait_cyc(k + 400);
      start = 1'b0;
      drain("held_start");
      repeat (60) @(posedge clk);
      #1 chk("held_start_stops", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
